// File: rtl/queue_pkg.sv
// Shared definitions for the single-port RAM queue and its port arbiter.
package queue_pkg;

    localparam int unsigned QUEUE_DW    = 8;
    localparam int unsigned QUEUE_DEPTH = 1024;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        TURN
    } qarb_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

endpackage

// File: rtl/queue_port_arbiter_if.sv
// Requester-side handshake bundle of the queue port arbiter.
interface queue_port_arbiter_if
    import queue_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = QUEUE_DW
) ();

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      rd_data;
    logic [NREQ-1:0]    rd_valid;

    modport master (
        output req,
        output req_wr,
        output req_wdata,
        input  gnt,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  req,
        input  req_wr,
        input  req_wdata,
        output gnt,
        output rd_data,
        output rd_valid
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
module rr_pick
    import queue_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IW-1:0]   win_idx
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = IW'((32'(ptr) + off) % NREQ);
            if (!found && elig[idx]) begin
                found       = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/queue_port_arbiter.sv
// Shares the single-port RAM queue between NREQ push/pop requesters, owning the
// queue strobes, the write side of the bus, pop-data return and flag checking.
module queue_port_arbiter
    import queue_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DW    = QUEUE_DW,
    parameter int unsigned DEPTH = QUEUE_DEPTH,
    localparam int unsigned IW   = clog2(NREQ),
    localparam int unsigned LW   = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    queue_port_arbiter_if.slave   bus,
    output logic                  q_en,
    output logic                  q_rw,
    inout  wire  [DW-1:0]         q_io,
    input  logic                  q_empty,
    input  logic                  q_full,
    output logic [LW-1:0]         level,
    output logic                  err
);

    qarb_state_t     state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_next;
    logic [IW-1:0]   owner_q;
    logic [LW-1:0]   level_q;
    logic [DW-1:0]   wdata_q, rd_data_q, wdata_sel;
    logic [NREQ-1:0] rd_valid_q;
    logic            q_en_q, q_rw_q, err_q;

    logic [NREQ-1:0] elig, win_oh, gnt;
    logic [IW-1:0]   win_idx;
    logic            can_push, can_pop, any, wr_sel, grant;
    logic            full_exp, empty_exp;

    // Eligibility uses the arbiter's own count so in-flight ops are accounted for.
    assign can_push = level_q < LW'(DEPTH);
    assign can_pop  = level_q != '0;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            elig[i] = bus.req[i] && (bus.req_wr[i] ? can_push : can_pop);
        end
    end

    assign any = |elig;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .elig    (elig),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    always_comb begin
        wr_sel    = 1'b0;
        wdata_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                wr_sel    = bus.req_wr[i];
                wdata_sel = bus.req_wdata[i*DW +: DW];
            end
        end
    end

    assign ptr_next = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);

    // A push won while the queue is driving read data waits out a TURN cycle.
    always_comb begin
        state_d = IDLE;
        grant   = 1'b0;
        gnt     = '0;
        unique case (state_q)
            TURN: state_d = IDLE;
            default: begin
                if (any) begin
                    if (wr_sel && state_q == RD) begin
                        state_d = TURN;
                    end else begin
                        grant   = 1'b1;
                        gnt     = win_oh;
                        state_d = wr_sel ? WR : RD;
                    end
                end
            end
        endcase
    end

    assign full_exp  = level_q == LW'(DEPTH);
    assign empty_exp = level_q == '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            level_q    <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            q_en_q     <= 1'b0;
            q_rw_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_en_q     <= grant;
            q_rw_q     <= grant && wr_sel;
            rd_valid_q <= '0;
            if (grant) begin
                owner_q <= win_idx;
                ptr_q   <= ptr_next;
                if (wr_sel) begin
                    wdata_q <= wdata_sel;
                    level_q <= level_q + LW'(1);
                end else begin
                    level_q <= level_q - LW'(1);
                end
            end
            if (state_q == RD) begin
                rd_data_q           <= q_io;
                rd_valid_q[owner_q] <= 1'b1;
            end
            // Flags are only trusted when no queue access is in progress.
            if (!q_en_q && ((q_full != full_exp) || (q_empty != empty_exp))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign q_io         = (q_en_q && q_rw_q) ? wdata_q : {DW{1'bz}};
    assign q_en         = q_en_q;
    assign q_rw         = q_rw_q;
    assign level        = level_q;
    assign err          = err_q;
    assign bus.gnt      = gnt;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule
